// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix stream loader and the transposer bench.
// Holds the default geometry, the loader state encoding and the slot
// position helper that both sides use to agree on the flattened layout.
package matrix_pkg;

    localparam int MATRIX_SIZE_DEF = 4;
    localparam int DATA_WIDTH_DEF  = 8;

    // Loader state: collecting elements, or holding a finished matrix.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // MSB position of the k-th row-major element; element 0 sits in the MSBs.
    function automatic int slot_msb(input int k,
                                    input int n = MATRIX_SIZE_DEF,
                                    input int w = DATA_WIDTH_DEF);
        return n * n * w - 1 - k * w;
    endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: collects MATRIX_SIZE*MATRIX_SIZE elements arriving
// one per handshake in row-major order and presents them as one flattened
// word (element (0,0) in the MSBs) on a valid/ready output.
// Optional framing check: define MATRIX_LOADER_LAST_CHECK_EN to add the
// in_last input and the sticky frame_err output.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        clear,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    input  logic                                        in_valid,
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    input  logic                                        in_last,
    output logic                                        frame_err,
`endif
    output logic                                        in_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_out,
    output logic                                        mat_valid,
    input  logic                                        mat_ready
);

    localparam int NELEM = MATRIX_SIZE * MATRIX_SIZE;
    localparam int TOTW  = NELEM * DATA_WIDTH;
    localparam int CW    = $clog2(NELEM + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TOTW-1:0] mat_q, mat_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            accept;
    logic            consume;
    logic            last_elem;
    logic [NELEM-1:0] slot_we;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    logic            frame_err_q, frame_err_d;
`endif

    // clear outranks both handshakes, so neither side can fire in its cycle.
    assign accept    = in_valid && ready_q && !clear;
    assign consume   = valid_q && mat_ready && !clear;
    assign last_elem = (count_q == CW'(NELEM - 1));

    // One write strobe per slot, selected by the running element count.
    genvar gi;
    generate
        for (gi = 0; gi < NELEM; gi++) begin : g_slot
            assign slot_we[gi] = accept && (count_q == CW'(gi));
        end
    endgenerate

    // Slot write decoder: only the addressed element is replaced.
    always_comb begin
        mat_d = mat_q;
        for (int k = 0; k < NELEM; k++) begin
            if (slot_we[k]) begin
                mat_d[slot_msb(k, MATRIX_SIZE, DATA_WIDTH) -: DATA_WIDTH] = in_data;
            end
        end
    end

    // Next-state logic for the FILL/FULL controller and the element counter.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
        frame_err_d = frame_err_q;
`endif
        if (clear) begin
            state_d = FILL;
            count_d = '0;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
            frame_err_d = 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
`ifdef MATRIX_LOADER_LAST_CHECK_EN
                        if (in_last && !last_elem) begin
                            // Early end of frame: drop the partial matrix.
                            frame_err_d = 1'b1;
                            count_d     = '0;
                        end else begin
                            if (!in_last && last_elem) begin
                                frame_err_d = 1'b1;
                            end
`endif
                            if (last_elem) begin
                                state_d = FULL;
                                count_d = '0;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
`ifdef MATRIX_LOADER_LAST_CHECK_EN
                        end
`endif
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d = FILL;
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                end
            endcase
        end
        // Handshake flags are registered copies of the next state.
        ready_d = (state_d == FILL);
        valid_d = (state_d == FULL);
    end

    // State registers; reset clears everything including the matrix word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
            mat_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mat_q   <= mat_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign in_ready  = ready_q;
    assign mat_valid = valid_q;
    assign mat_out   = mat_q;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    assign frame_err = frame_err_q;
`endif

endmodule
